ikaopm_slotgen: RTL and testbench
=================================

IKAOPM_SLOTGEN -- requirements
Module: ikaopm_slotgen

Interface
REQ-001 SHALL have parameter SLOTS, default 32, slots per frame; power of two, 8..64; CW = log2(SLOTS).
REQ-002 SHALL have parameter SH_DELAY, default 5, SH pipeline stages, 0..8.
REQ-003 SHALL have parameter NDEC, default 4, number of programmable decode outputs, 1..8.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have the following ports:
- i_EMUCLK  in  1  master clock.
- i_IC  in  1  asynchronous, active-high reset.
- i_phiM_PCEN_n  in  1  phiM positive-edge clock enable, active-low.
- i_RESYNC  in  1  synchronous frame re-phase request.
- i_CFG_WR  in  1  decode-table write request, level, held until acked.
- i_CFG_ADDR  in  3  decode entry index.
- i_CFG_DATA  in  2*CW  {mask[CW-1:0], value[CW-1:0]}.
- o_CFG_ACK  out  1  one-EMUCLK write-commit pulse.
- o_phi1  out  1  phiM/2 reference clock.
- o_phi1_PCEN_n  out  1  phi1 positive-edge enable, active-low.
- o_phi1_NCEN_n  out  1  phi1 negative-edge enable, active-low.
- o_SLOT  out  CW  current slot counter.
- o_DEC  out  NDEC  registered decode strobes.
- o_SH1  out  1  first-half sample/hold strobe.
- o_SH2  out  1  second-half sample/hold strobe.

Function
REQ-006 SHALL toggle internal phi1p on every i_EMUCLK edge with i_phiM_PCEN_n=0, and SHALL load phi1n with the previous phi1p on the same edge.
REQ-007 SHALL drive o_phi1=phi1p, o_phi1_PCEN_n=phi1p|i_phiM_PCEN_n and o_phi1_NCEN_n=phi1n|i_phiM_PCEN_n; "NCEN edge" below means an i_EMUCLK edge with o_phi1_NCEN_n=0.
REQ-008 SHALL change the slot counter only on NCEN edges: i_RESYNC=1 loads 0, otherwise SLOTS-1 wraps to 0, otherwise the counter increments; i_RESYNC has priority over wrap.
REQ-009 SHALL register o_DEC[k] on each NCEN edge as ((cntr & mask_k) == (value_k & mask_k)), using the pre-edge counter, so each strobe lags its slot by one phi1 cycle.
REQ-010 SHALL reset decode entry k to mask = all-ones and value = 8k mod SLOTS.
REQ-011 SHALL commit i_CFG_DATA to entry i_CFG_ADDR on an NCEN edge with i_CFG_WR=1, and SHALL pulse o_CFG_ACK for exactly the next i_EMUCLK cycle.
REQ-012 SHALL still ack writes with i_CFG_ADDR>=NDEC but SHALL discard their data.
REQ-013 SHALL rewrite the same entry at each NCEN edge while i_CFG_WR is held, acking each write.
REQ-014 SHALL evaluate the decode at the commit edge with the old entry; the new entry takes effect from the following NCEN edge.
REQ-015 SHALL compute raw sh1 = cntr[CW-1:CW-2]==2'b01 and raw sh2 = cntr[CW-1:CW-2]==2'b11.
REQ-016 SHALL delay sh1/sh2 through SH_DELAY NCEN-clocked stages plus one output register, AND-ed with a run flag.
REQ-017 SHALL set the run flag at the first increment wrap after reset; the flag SHALL never clear except by reset, and i_RESYNC SHALL NOT set it.

Reset
REQ-018 SHALL, while i_IC=1 and without a clock edge, force phi1p=1, phi1n=1, o_phi1_PCEN_n=1, o_phi1_NCEN_n=1, o_SLOT=0, o_DEC=0, o_SH1=0, o_SH2=0, o_CFG_ACK=0, run=0, all SH stages to 0 and the decode table to its reset values.
REQ-019 SHALL abort any pending write on reset mid-operation; the requester re-issues it.

Configuration
REQ-020 SHALL, with IKAOPM_SLOTGEN_FRAME_CNT_EN defined, add output o_FRAME_CNT[15:0], reset 0, incremented on each increment wrap (not on i_RESYNC), wrapping 0xFFFF->0; without the macro the port and its logic SHALL be absent.

Verification
REQ-021 SHALL cover: i_phiM_PCEN_n low 1-in-4 EMUCLK, i_IC released -> o_phi1 toggles every 4 EMUCLK, o_SLOT steps 0..31,0 every 8 EMUCLK.
REQ-022 SHALL cover: default table -> o_DEC[1] high exactly while o_SLOT=9, once per frame.
REQ-023 SHALL cover: write addr=1, mask=0x07, value=0x03 -> o_CFG_ACK one cycle; o_DEC[1] high while o_SLOT in {4,12,20,28}; write to addr=6 acked, o_DEC unchanged.
REQ-024 SHALL cover: i_RESYNC at slot 20 -> next o_SLOT=0; i_RESYNC at slot 31 -> 0, and o_FRAME_CNT (macro on) not incremented.
REQ-025 SHALL cover: SH_DELAY=5 -> o_SH1, o_SH2 =0 in the first frame; afterwards o_SH1 high while o_SLOT in 14..21 and o_SH2 high while o_SLOT in 30..31,0..5.
REQ-026 SHALL cover: i_IC asserted at slot 17 -> all outputs at reset values immediately; o_phi1=1.

Source files
------------

// File: rtl/ikaopm_slotgen.sv
// OPM-style slot generator: phi1 derivation from phiM, slot counter, programmable slot decode and SH strobes.
// Optional feature: define IKAOPM_SLOTGEN_FRAME_CNT_EN to add the o_FRAME_CNT frame counter output.
module ikaopm_slotgen #(
  parameter int SLOTS    = 32,
  parameter int SH_DELAY = 5,
  parameter int NDEC     = 4,
  localparam int CW      = $clog2(SLOTS)
) (
  input  logic            i_EMUCLK,
  input  logic            i_IC,
  input  logic            i_phiM_PCEN_n,
  input  logic            i_RESYNC,
  input  logic            i_CFG_WR,
  input  logic [2:0]      i_CFG_ADDR,
  input  logic [2*CW-1:0] i_CFG_DATA,
  output logic            o_CFG_ACK,
  output logic            o_phi1,
  output logic            o_phi1_PCEN_n,
  output logic            o_phi1_NCEN_n,
  output logic [CW-1:0]   o_SLOT,
  output logic [NDEC-1:0] o_DEC,
  output logic            o_SH1,
`ifdef IKAOPM_SLOTGEN_FRAME_CNT_EN
  output logic [15:0]     o_FRAME_CNT,
`endif
  output logic            o_SH2
);

  logic phi1p_q, phi1n_q;
  logic ncen;

  assign ncen = ~(phi1n_q | i_phiM_PCEN_n);

  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC) begin
      phi1p_q <= 1'b1;
      phi1n_q <= 1'b1;
    end else if (!i_phiM_PCEN_n) begin
      phi1p_q <= ~phi1p_q;
      phi1n_q <= phi1p_q;
    end
  end

  logic [CW-1:0] cntr_q, cntr_d;
  logic          wrap;
  logic          run_q, run_d;

  // Only a natural wrap counts as a frame boundary; a resync never does.
  assign wrap  = ncen & ~i_RESYNC & (cntr_q == CW'(SLOTS - 1));
  assign run_d = run_q | wrap;

  always_comb begin
    cntr_d = cntr_q;
    if (ncen) cntr_d = i_RESYNC ? '0 : cntr_q + CW'(1);
  end

  logic [CW-1:0]   mask_q [NDEC];
  logic [CW-1:0]   val_q  [NDEC];
  logic [NDEC-1:0] dec_d, dec_q;
  logic            ack_q;

  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC) begin
      for (int k = 0; k < NDEC; k++) begin
        mask_q[k] <= '1;
        val_q[k]  <= CW'((8 * k) % SLOTS);
      end
    end else if (ncen && i_CFG_WR) begin
      // Addresses with no matching entry fall through: acked, data dropped.
      for (int k = 0; k < NDEC; k++) begin
        if (i_CFG_ADDR == 3'(k)) begin
          mask_q[k] <= i_CFG_DATA[2*CW-1:CW];
          val_q[k]  <= i_CFG_DATA[CW-1:0];
        end
      end
    end
  end

  always_comb begin
    dec_d = '0;
    for (int k = 0; k < NDEC; k++)
      dec_d[k] = ((cntr_q & mask_q[k]) == (val_q[k] & mask_q[k]));
  end

  logic sh1_raw, sh2_raw, sh1_tap, sh2_tap;
  logic sh1_q, sh2_q;

  assign sh1_raw = (cntr_q[CW-1:CW-2] == 2'b01);
  assign sh2_raw = (cntr_q[CW-1:CW-2] == 2'b11);

  generate
    if (SH_DELAY == 0) begin : g_sh_direct
      assign sh1_tap = sh1_raw;
      assign sh2_tap = sh2_raw;
    end else begin : g_sh_pipe
      logic [SH_DELAY-1:0] sh1_pipe_q, sh2_pipe_q;
      always_ff @(posedge i_EMUCLK or posedge i_IC) begin
        if (i_IC) begin
          sh1_pipe_q <= '0;
          sh2_pipe_q <= '0;
        end else if (ncen) begin
          sh1_pipe_q[0] <= sh1_raw;
          sh2_pipe_q[0] <= sh2_raw;
          for (int i = 1; i < SH_DELAY; i++) begin
            sh1_pipe_q[i] <= sh1_pipe_q[i-1];
            sh2_pipe_q[i] <= sh2_pipe_q[i-1];
          end
        end
      end
      assign sh1_tap = sh1_pipe_q[SH_DELAY-1];
      assign sh2_tap = sh2_pipe_q[SH_DELAY-1];
    end
  endgenerate

  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC) begin
      cntr_q <= '0;
      run_q  <= 1'b0;
      dec_q  <= '0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      run_q  <= run_d;
      ack_q  <= ncen & i_CFG_WR;
      if (ncen) begin
        dec_q <= dec_d;
        sh1_q <= sh1_tap & run_d;
        sh2_q <= sh2_tap & run_d;
      end
    end
  end

`ifdef IKAOPM_SLOTGEN_FRAME_CNT_EN
  logic [15:0] frame_q;
  always_ff @(posedge i_EMUCLK or posedge i_IC) begin
    if (i_IC)      frame_q <= 16'd0;
    else if (wrap) frame_q <= frame_q + 16'd1;
  end
  assign o_FRAME_CNT = frame_q;
`endif

  assign o_phi1        = phi1p_q;
  assign o_phi1_PCEN_n = phi1p_q | i_phiM_PCEN_n;
  assign o_phi1_NCEN_n = phi1n_q | i_phiM_PCEN_n;
  assign o_SLOT        = cntr_q;
  assign o_DEC         = dec_q;
  assign o_SH1         = sh1_q;
  assign o_SH2         = sh2_q;
  assign o_CFG_ACK     = ack_q;

endmodule

// File: tb/tb_ikaopm_slotgen.sv
// Bench for ikaopm_slotgen (default parameters): behavioural model feeds an expected-output queue,
// compared on the falling edge against the DUT.
module tb_ikaopm_slotgen;
  localparam int CW   = 5;
  localparam int NDEC = 4;
  localparam int W    = 1 + 1 + 1 + NDEC + CW;

  logic            clk = 1'b0;
  logic            ic = 1'b1;
  logic            pcen_n = 1'b1;
  logic            resync = 1'b0;
  logic            cfg_wr = 1'b0;
  logic [2:0]      cfg_addr = 3'd0;
  logic [2*CW-1:0] cfg_data = '0;
  logic            o_CFG_ACK, o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n, o_SH1, o_SH2;
  logic [CW-1:0]   o_SLOT;
  logic [NDEC-1:0] o_DEC;
`ifdef IKAOPM_SLOTGEN_FRAME_CNT_EN
  logic [15:0]     o_FRAME_CNT;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  ikaopm_slotgen dut (
    .i_EMUCLK      (clk),
    .i_IC          (ic),
    .i_phiM_PCEN_n (pcen_n),
    .i_RESYNC      (resync),
    .i_CFG_WR      (cfg_wr),
    .i_CFG_ADDR    (cfg_addr),
    .i_CFG_DATA    (cfg_data),
    .o_CFG_ACK     (o_CFG_ACK),
    .o_phi1        (o_phi1),
    .o_phi1_PCEN_n (o_phi1_PCEN_n),
    .o_phi1_NCEN_n (o_phi1_NCEN_n),
    .o_SLOT        (o_SLOT),
    .o_DEC         (o_DEC),
    .o_SH1         (o_SH1),
`ifdef IKAOPM_SLOTGEN_FRAME_CNT_EN
    .o_FRAME_CNT   (o_FRAME_CNT),
`endif
    .o_SH2         (o_SH2)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // phiM enable: low one EMUCLK in four
  initial begin
    int pc = 0;
    forever begin
      @(posedge clk); #2;
      pc = (pc + 1) % 4;
      pcen_n = (pc != 3);
    end
  end

  // behavioural model
  logic       m_p = 1'b1, m_n = 1'b1, m_ack = 1'b0, m_sh1 = 1'b0, m_sh2 = 1'b0, m_run = 1'b0;
  int         m_slot = 0;
  int         m_frames = 0;
  logic [3:0] m_dec = '0;
  logic [4:0] m_p1 = '0, m_p2 = '0;
  int         m_mask [NDEC];
  int         m_val  [NDEC];

  always @(posedge clk or posedge ic) begin
    if (ic) begin
      m_p = 1'b1; m_n = 1'b1; m_ack = 1'b0; m_sh1 = 1'b0; m_sh2 = 1'b0; m_run = 1'b0;
      m_slot = 0; m_frames = 0; m_dec = '0; m_p1 = '0; m_p2 = '0;
      for (int k = 0; k < NDEC; k++) begin
        m_mask[k] = 31;
        m_val[k]  = (8 * k) % 32;
      end
      exp_q.delete();
    end else begin
      logic nc;
      nc = !m_n && !pcen_n;
      m_ack = nc && cfg_wr;
      if (nc) begin
        for (int k = 0; k < NDEC; k++)
          m_dec[k] = ((m_slot & m_mask[k]) == (m_val[k] & m_mask[k]));
        if (!resync && m_slot == 31) begin
          m_run = 1'b1;
          m_frames = (m_frames + 1) % 65536;
        end
        m_sh1 = m_p1[4] & m_run;
        m_sh2 = m_p2[4] & m_run;
        m_p1 = {m_p1[3:0], (m_slot / 8) == 1};
        m_p2 = {m_p2[3:0], (m_slot / 8) == 3};
        if (cfg_wr && cfg_addr < NDEC) begin
          m_mask[cfg_addr] = int'(cfg_data[2*CW-1:CW]);
          m_val[cfg_addr]  = int'(cfg_data[CW-1:0]);
        end
        m_slot = resync ? 0 : (m_slot + 1) % 32;
      end
      if (!pcen_n) begin
        m_n = m_p;
        m_p = !m_p;
      end
      exp_q.push_back({m_ack, m_sh2, m_sh1, m_dec, 5'(m_slot)});
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (ic) begin
      check("rst_slot", o_SLOT, 0);
      check("rst_dec", o_DEC, 0);
      check("rst_sh", {o_SH1, o_SH2}, 0);
      check("rst_ack", o_CFG_ACK, 0);
      check("rst_phi", {o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n}, 3'b111);
    end else if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("slot", o_SLOT, e[CW-1:0]);
      check("dec", o_DEC, e[CW+NDEC-1:CW]);
      check("sh1", o_SH1, e[W-3]);
      check("sh2", o_SH2, e[W-2]);
      check("ack", o_CFG_ACK, e[W-1]);
      check("phi1", o_phi1, m_p);
      check("pcen", o_phi1_PCEN_n, m_p | pcen_n);
      check("ncen", o_phi1_NCEN_n, m_n | pcen_n);
`ifdef IKAOPM_SLOTGEN_FRAME_CNT_EN
      check("frame_cnt", o_FRAME_CNT, m_frames);
`endif
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_slot(input int s);
    logic found;
    found = (m_slot == s);
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1);
      found = (m_slot == s);
    end
    check("wait_slot", found, 1'b1);
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [2*CW-1:0] data);
    logic got;
    got = 1'b0;
    cfg_addr = addr;
    cfg_data = data;
    cfg_wr   = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_CFG_ACK) got = 1'b1;
    end
    check("ack_seen", got, 1'b1);
    @(posedge clk); #2;
    cfg_wr = 1'b0;
  endtask

  task automatic resync_at(input int s);
    logic moved;
    wait_slot(s);
    resync = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 20 && !moved; i++) begin
      tick(1);
      moved = (m_slot != s);
    end
    resync = 1'b0;
    check("resync_moved", moved, 1'b1);
    @(negedge clk);
    check("resync_slot", o_SLOT, 0);
  endtask

  initial begin
    tick(6);
    ic = 1'b0;
    // three frames: first-frame SH blanking, then steady strobes and default decode
    tick(3 * 32 * 8 + 40);
    cfg_write(3'd1, {5'h07, 5'h03});
    tick(32 * 8 + 16);
    cfg_write(3'd6, {5'h00, 5'h00});
    tick(32 * 8);
    resync_at(20);
    tick(40);
    resync_at(31);
    tick(64);
    // reset with a write still pending
    wait_slot(17);
    cfg_addr = 3'd2;
    cfg_data = {5'h00, 5'h00};
    cfg_wr   = 1'b1;
    tick(2);
    #1;
    ic = 1'b1;
    #1;
    check("ic_now_slot", o_SLOT, 0);
    check("ic_now_dec", o_DEC, 0);
    check("ic_now_sh", {o_SH1, o_SH2}, 0);
    check("ic_now_ack", o_CFG_ACK, 0);
    check("ic_now_phi", {o_phi1, o_phi1_PCEN_n, o_phi1_NCEN_n}, 3'b111);
    cfg_wr = 1'b0;
    tick(4);
    ic = 1'b0;
    tick(2 * 32 * 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
